// File: rtl/sprite_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// sprite_cmd_sequencer
//
// Upstream stage of the sprite display blocks. Software writes 32-bit sprite
// commands over Avalon-MM; they are queued in a small FIFO and forwarded one per
// cycle on a shared command bus (cmd_out, 32'h0 = idle). Every normal command is
// stamped with the current back-buffer select in bit 13. A "commit" command
// (info field == 4'b1111) is not forwarded as-is: it parks at the head of the
// queue until the start of vertical blanking, then turns into one ping-pong
// flush that swaps front/back buffers, so swaps never tear mid-frame.
//
// Optional feature (macro SEQ_DROP_COUNT_EN):
//   defined   - waitrequest tied low; writes while full are discarded and
//               counted in drop_count (saturating, cleared only by reset).
//   undefined - waitrequest back-pressures while full; no drop_count port.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   write        Avalon write strobe, qualified by chipselect
//   chipselect   Avalon select
//   writedata    command word [31:26] sub_comp [25:21] child [20:17] info
//                [16:14] type [13] pp_selc [12:0] msg
//   waitrequest  high while the FIFO is full
//   hcount       VGA horizontal count (unused)
//   vcount       VGA vertical count, used to detect vblank start
//   cmd_out      command bus to display blocks
//   front_sel    buffer currently displayed
//   frame_count  number of flushes issued (wraps)
//   fifo_count   current FIFO occupancy
//   drop_count   discarded writes (only with SEQ_DROP_COUNT_EN)
// -----------------------------------------------------------------------------
module sprite_cmd_sequencer #(
  parameter int DEPTH       = 16,
  parameter int VBLANK_LINE = 480
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write,
  input  logic                     chipselect,
  input  logic [31:0]              writedata,
  output logic                     waitrequest,
  input  logic [9:0]               hcount,
  input  logic [9:0]               vcount,
  output logic [31:0]              cmd_out,
  output logic                     front_sel,
  output logic [15:0]              frame_count,
  output logic [$clog2(DEPTH):0]   fifo_count
`ifdef SEQ_DROP_COUNT_EN
  ,
  output logic [15:0]              drop_count
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    S_DRAIN,
    S_WAIT_VBLANK,
    S_FLUSH
  } state_e;

  // Stored entry: {commit tag, word[31:14], word[12:0]}. The incoming bit 13 is
  // dropped at push because it is always replaced by the back select at pop.
  logic [31:0]   mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;

  state_e        state_q, state_d;
  logic [31:0]   cmd_q, cmd_d;
  logic          front_q;
  logic [15:0]   frame_q;
  logic [9:0]    vcount_q;

  logic          full, empty, push, pop, swap;
  logic          back;
  logic          vblank_pulse;
  logic [31:0]   head;
  logic          head_commit;
  logic          unused_hcount;

  assign unused_hcount = ^hcount;

  assign full  = (count_q == CW'(DEPTH));
  assign empty = (count_q == '0);

`ifdef SEQ_DROP_COUNT_EN
  logic        drop;
  logic [15:0] drop_q;

  assign waitrequest = 1'b0;
  assign push        = write & chipselect & ~full;
  assign drop        = write & chipselect & full;
  assign drop_count  = drop_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      drop_q <= '0;
    end else if (drop && (drop_q != 16'hFFFF)) begin
      drop_q <= drop_q + 16'd1;
    end
  end
`else
  assign waitrequest = full;
  assign push        = write & chipselect & ~waitrequest;
`endif

  assign back         = ~front_q;
  assign head         = mem_q[rd_ptr_q];
  assign head_commit  = head[31];
  // Only the first cycle of vcount == VBLANK_LINE counts, so a line that is
  // held for many clocks still produces a single pulse per frame.
  assign vblank_pulse = (vcount == 10'(VBLANK_LINE)) && (vcount_q != 10'(VBLANK_LINE));

  // NOTE: storage has no reset; the pointers and count define which entries
  // are valid, so clearing the array would only add reset fan-out.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {(writedata[20:17] == 4'b1111), writedata[31:14], writedata[12:0]};
    end
  end

  // NOTE: always_comb assigns every output a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    cmd_d   = 32'h0;
    pop     = 1'b0;
    swap    = 1'b0;
    unique case (state_q)
      S_DRAIN: begin
        if (!empty) begin
          if (head_commit) begin
            // A vblank pulse in this cycle is deliberately missed: the flush
            // waits a full frame rather than racing the current one.
            state_d = S_WAIT_VBLANK;
          end else begin
            pop   = 1'b1;
            cmd_d = {head[30:13], back, head[12:0]};
          end
        end
      end
      S_WAIT_VBLANK: begin
        if (vblank_pulse) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        pop     = 1'b1;
        swap    = 1'b1;
        cmd_d   = {6'b0, 5'b0, 4'b1111, 3'b0, back, 13'b0};
        state_d = S_DRAIN;
      end
      default: state_d = S_DRAIN;
    endcase
  end

  always_comb begin
    count_d = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_DRAIN;
      cmd_q    <= '0;
      front_q  <= 1'b0;
      frame_q  <= '0;
      vcount_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      cmd_q    <= cmd_d;
      vcount_q <= vcount;
      count_q  <= count_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (swap) begin
        front_q <= back;
        frame_q <= frame_q + 16'd1;
      end
    end
  end

  assign cmd_out     = cmd_q;
  assign front_sel   = front_q;
  assign frame_count = frame_q;
  assign fifo_count  = count_q;

endmodule
